rival_frame_rx: RTL

Receive-side frame decoder for the two-board game link. Consumes the byte stream from the UART receiver (one strobe per received byte) and turns it into the control signals the game state machine reads from the rival board: a one-cycle `start_sig` pulse and a registered `rival_score`. It is the counterpart of the score/start frame packer on the transmitting board, and also reports framing errors and link status.

---
 rtl/rival_frame_rx.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/rival_frame_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rival_frame_rx                                                             |
// | Decodes SOF/TYPE/PAYLOAD[/CHK] byte frames from the rival board into       |
// | start/score pulses, with error counting and link status.                   |
// | Optional CHK byte build macro: RIVAL_FRAME_CHECKSUM_EN                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rival_frame_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  SOF_BYTE       = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [7:0] rival_score,
  output logic       score_valid,
  output logic       start_sig,
  output logic       frame_err,
  output logic [7:0] err_cnt,
  output logic       link_up
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    TYPE_START = 8'h01;
  localparam logic [7:0]    TYPE_SCORE = 8'h02;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_TYPE    = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CHK     = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          is_score_q, is_score_d;
  logic [7:0]    rival_score_q, rival_score_d;
  logic          score_valid_q, score_valid_d;
  logic          start_q, start_d;
  logic          frame_err_q, frame_err_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic          link_up_q, link_up_d;
`ifdef RIVAL_FRAME_CHECKSUM_EN
  logic [7:0]    payload_q, payload_d;
`endif

  logic       commit;
  logic       reject;
  logic [7:0] commit_payload;

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    is_score_d     = is_score_q;
    rival_score_d  = rival_score_q;
    score_valid_d  = 1'b0;
    start_d        = 1'b0;
    link_up_d      = link_up_q;
    commit         = 1'b0;
    reject         = 1'b0;
    commit_payload = rx_data;
`ifdef RIVAL_FRAME_CHECKSUM_EN
    payload_d      = payload_q;
`endif

    // A strobe always wins over a coincident timeout expiry.
    if (rx_done) begin
      timer_d = '0;
      case (state_q)
        ST_HUNT: begin
          if (rx_data == SOF_BYTE) state_d = ST_TYPE;
        end
        ST_TYPE: begin
          if (rx_data == TYPE_SCORE || rx_data == TYPE_START) begin
            is_score_d = (rx_data == TYPE_SCORE);
            state_d    = ST_PAYLOAD;
          end else begin
            reject  = 1'b1;
            state_d = ST_HUNT;
          end
        end
        ST_PAYLOAD: begin
`ifdef RIVAL_FRAME_CHECKSUM_EN
          payload_d = rx_data;
          state_d   = ST_CHK;
`else
          commit    = 1'b1;
          state_d   = ST_HUNT;
`endif
        end
`ifdef RIVAL_FRAME_CHECKSUM_EN
        ST_CHK: begin
          commit_payload = payload_q;
          if (rx_data == ((is_score_q ? TYPE_SCORE : TYPE_START) ^ payload_q)) commit = 1'b1;
          else                                                                  reject = 1'b1;
          state_d = ST_HUNT;
        end
`endif
        default: state_d = ST_HUNT;
      endcase
    end else if (state_q != ST_HUNT) begin
      if (timer_q == TMO_LAST) begin
        reject  = 1'b1;
        state_d = ST_HUNT;
        timer_d = '0;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end

    if (commit) begin
      link_up_d = 1'b1;
      if (is_score_q) begin
        rival_score_d = commit_payload;
        score_valid_d = 1'b1;
      end else begin
        start_d = 1'b1;
      end
    end

    frame_err_d = reject;
    err_cnt_d   = (reject && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_HUNT;
      timer_q       <= '0;
      is_score_q    <= 1'b0;
      rival_score_q <= 8'h00;
      score_valid_q <= 1'b0;
      start_q       <= 1'b0;
      frame_err_q   <= 1'b0;
      err_cnt_q     <= 8'h00;
      link_up_q     <= 1'b0;
`ifdef RIVAL_FRAME_CHECKSUM_EN
      payload_q     <= 8'h00;
`endif
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      is_score_q    <= is_score_d;
      rival_score_q <= rival_score_d;
      score_valid_q <= score_valid_d;
      start_q       <= start_d;
      frame_err_q   <= frame_err_d;
      err_cnt_q     <= err_cnt_d;
      link_up_q     <= link_up_d;
`ifdef RIVAL_FRAME_CHECKSUM_EN
      payload_q     <= payload_d;
`endif
    end
  end

  assign rival_score = rival_score_q;
  assign score_valid = score_valid_q;
  assign start_sig   = start_q;
  assign frame_err   = frame_err_q;
  assign err_cnt     = err_cnt_q;
  assign link_up     = link_up_q;

endmodule
`default_nettype wire
